button_press_classifier: RTL and testbench



---
 rtl/button_press_classifier.sv | 109 ++++++++++
 tb/tb_button_press_classifier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short or long and emits one-cycle event pulses.
// Define AUTOREPEAT_EN to enable periodic repeat_pulse while a long press is held.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_db,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       hold_active,
    output logic [3:0] press_count
);

    localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("button_press_classifier: LONG_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {ARM, IDLE, PRESSED, LONG} state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    // ARM waits for a low sample so a button held through reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARM;
            hold_cnt    <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            hold_active <= 1'b0;
            press_count <= 4'd0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (state)
                ARM: begin
                    if (!btn_db) state <= IDLE;
                end
                IDLE: begin
                    if (btn_db) begin
                        state    <= PRESSED;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_db) begin
                        state       <= IDLE;
                        short_pulse <= 1'b1;
                        press_count <= press_count + 4'd1;
                        hold_cnt    <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= LONG;
                        long_pulse  <= 1'b1;
                        hold_active <= 1'b1;
                        press_count <= press_count + 4'd1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                LONG: begin
                    if (!btn_db) begin
                        state       <= IDLE;
                        hold_active <= 1'b0;
                        hold_cnt    <= '0;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;

    // rep_cnt is held at zero outside a held long press, so it starts fresh on entry to LONG.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (state == LONG && btn_db) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt      <= '0;
                    repeat_pulse <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed scenarios plus random press/release runs
// checked cycle by cycle against a press-length reference model.
module tb_button_press_classifier;

    localparam int LONG_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;

    logic       clk;
    logic       reset;
    logic       btn_db;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       hold_active;
    logic [3:0] press_count;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: press length in high samples, and whether a low was seen since reset.
    bit         armed;
    int         run;
    logic [3:0] m_cnt;
    bit         m_short, m_long, m_rep, m_hold;

    button_press_classifier #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_db      (btn_db),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .hold_active (hold_active),
        .press_count (press_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed   = 1'b0;
        run     = 0;
        m_cnt   = 4'd0;
        m_short = 1'b0;
        m_long  = 1'b0;
        m_rep   = 1'b0;
        m_hold  = 1'b0;
    endtask

    task automatic model_step(input bit b);
        m_short = 1'b0;
        m_long  = 1'b0;
        m_rep   = 1'b0;
        if (!armed) begin
            if (!b) armed = 1'b1;
        end else if (b) begin
            run++;
            if (run == LONG_CYCLES) begin
                m_long = 1'b1;
                m_cnt  = m_cnt + 4'd1;
            end
`ifdef AUTOREPEAT_EN
            if (run > LONG_CYCLES && ((run - LONG_CYCLES) % REPEAT_CYCLES) == 0) m_rep = 1'b1;
`endif
        end else begin
            if (run > 0 && run < LONG_CYCLES) begin
                m_short = 1'b1;
                m_cnt   = m_cnt + 4'd1;
            end
            run = 0;
        end
        m_hold = (run >= LONG_CYCLES);
    endtask

    task automatic check_outputs(input string where);
        check({where, ".short"},  int'(short_pulse),  int'(m_short));
        check({where, ".long"},   int'(long_pulse),   int'(m_long));
        check({where, ".repeat"}, int'(repeat_pulse), int'(m_rep));
        check({where, ".hold"},   int'(hold_active),  int'(m_hold));
        check({where, ".count"},  int'(press_count),  int'(m_cnt));
        check({where, ".excl"},   int'(short_pulse & long_pulse), 0);
    endtask

    // Called just after a negedge; drives the sample for the next posedge and checks at the following negedge.
    task automatic cycle(input bit b);
        btn_db = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic cycles(input bit b, input int n);
        for (int i = 0; i < n; i++) cycle(b);
    endtask

    // Asserts reset between clock edges and checks that outputs clear without a clock edge.
    task automatic do_reset(input bit b);
        btn_db = b;
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int hi, lo;
        btn_db = 1'b0;
        reset  = 1'b1;
        model_reset();
        #5 reset = 1'b0;
        #1;
        check_outputs("por");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // short press of 3 samples
        cycles(0, 2);
        cycles(1, 3);
        cycles(0, 3);
        check("short3.count", int'(press_count), 1);

        // long press of 20 samples
        cycles(1, 20);
        cycles(0, 3);
        check("long20.count", int'(press_count), 2);

        // threshold edges: 7 samples short, 8 samples long
        cycles(1, LONG_CYCLES - 1);
        cycles(0, 2);
        cycles(1, LONG_CYCLES);
        cycles(0, 2);
        check("edge.count", int'(press_count), 4);

        // one-sample press and back-to-back release/press
        cycles(1, 1);
        cycles(0, 1);
        cycles(1, 1);
        cycles(0, 2);

        // button held through reset release is ignored
        do_reset(1);
        cycles(1, 30);
        cycles(0, 2);
        check("armed.count", int'(press_count), 0);
        cycles(1, 2);
        cycles(0, 2);
        check("armed.next", int'(press_count), 1);

        // 17 short presses wrap the counter, then reset mid-press
        do_reset(0);
        cycles(0, 1);
        for (int i = 0; i < 17; i++) begin
            cycle(1);
            cycle(0);
        end
        check("wrap.count", int'(press_count), 1);
        cycles(1, 2);
        do_reset(1);
        cycles(1, 3);
        cycles(0, 2);

        // random press/release runs around the threshold, with occasional resets
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 29) == 0) do_reset(1'($urandom_range(0, 1)));
            hi = int'($urandom_range(1, 2 * LONG_CYCLES - 2));
            lo = int'($urandom_range(1, 3));
            cycles(1, hi);
            cycles(0, lo);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
